gin_mcast: RTL

Parametrised successor global input network (GIN) for the PE array. It buffers incoming tagged words in a small FIFO and multicasts each word to every controller whose scan-programmed tag matches the word's tag. A word is delivered only when all matching units are ready (all-or-nothing). It adds broadcast, valid/ready backpressure and drop accounting for unmatched tags.

---
 rtl/gin_mcast_if.sv | 25 ++
 rtl/gin_mcast.sv | 126 ++++++++++++
 2 files changed

// File: rtl/gin_mcast_if.sv
// gin_mcast_if: word-input and per-controller delivery bundle of the GIN.
// master = source/controllers side, slave = gin_mcast.
interface gin_mcast_if #(
    parameter int BITWIDTH        = 16,
    parameter int TAG_LENGTH      = 4,
    parameter int NUM_CONTROLLERS = 10
);
    logic                                in_valid;
    logic                                in_ready;
    logic [TAG_LENGTH-1:0]               in_tag;
    logic [BITWIDTH-1:0]                 in_data;
    logic [NUM_CONTROLLERS-1:0]          unit_ready;
    logic [BITWIDTH*NUM_CONTROLLERS-1:0] output_value;
    logic [NUM_CONTROLLERS-1:0]          unit_enable;

    modport master (
        output in_valid, in_tag, in_data, unit_ready,
        input  in_ready, output_value, unit_enable
    );

    modport slave (
        input  in_valid, in_tag, in_data, unit_ready,
        output in_ready, output_value, unit_enable
    );
endinterface

// File: rtl/gin_mcast.sv
// gin_mcast: tagged-word FIFO with all-or-nothing multicast to controllers.
// Ports: clk, rstb (sync, active-low), program_i (scan shift), scan_tag_in,
//   scan_tag_out (chain out), enable, bus (gin_mcast_if.slave: input
//   handshake, unit_ready, output_value, unit_enable), busy, drop_count.
module gin_mcast #(
    parameter int BITWIDTH        = 16,
    parameter int TAG_LENGTH      = 4,
    parameter int NUM_CONTROLLERS = 10,
    parameter int FIFO_DEPTH      = 4,
    parameter int DROP_CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  program_i,
    input  logic [TAG_LENGTH-1:0] scan_tag_in,
    output logic [TAG_LENGTH-1:0] scan_tag_out,
    input  logic                  enable,
    gin_mcast_if.slave            bus,
    output logic                  busy,
    output logic [DROP_CNT_W-1:0] drop_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = TAG_LENGTH + BITWIDTH;

    logic [TAG_LENGTH-1:0]      tag_q [NUM_CONTROLLERS];
    logic [BITWIDTH-1:0]        val_q [NUM_CONTROLLERS];
    logic [ENT_W-1:0]           mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_q, wr_d;
    logic [PTR_W-1:0]           rd_q, rd_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [DROP_CNT_W-1:0]      drop_q, drop_d;
    logic [NUM_CONTROLLERS-1:0] en_q, en_d;

    logic [TAG_LENGTH-1:0]      head_tag;
    logic [BITWIDTH-1:0]        head_data;
    logic [NUM_CONTROLLERS-1:0] match;
    logic                       active, push, deliver, drop, pop;

    assign head_tag  = mem_q[rd_q][ENT_W-1:BITWIDTH];
    assign head_data = mem_q[rd_q][BITWIDTH-1:0];

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_CONTROLLERS; i++) begin
            match[i] = (head_tag == '1) || (head_tag == tag_q[i]);
        end
    end

    // in_ready and busy are forced low while reset is asserted.
    assign bus.in_ready = rstb & enable & ~program_i
                        & (cnt_q < CNT_W'(FIFO_DEPTH));
    assign busy         = rstb & (cnt_q != '0);

    assign push    = bus.in_valid & bus.in_ready;
    assign active  = enable & ~program_i & (cnt_q != '0);
    assign drop    = active & (match == '0);
    // Deliver only when every matching controller is ready.
    assign deliver = active & (match != '0)
                   & ((match & ~bus.unit_ready) == '0);
    assign pop     = drop | deliver;

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        drop_d = drop_q;
        en_d   = '0;
        if (push) wr_d = wr_q + 1'b1;
        if (pop)  rd_d = rd_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (drop && drop_q != '1) drop_d = drop_q + 1'b1;
        if (deliver) en_d = match;
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            for (int i = 0; i < NUM_CONTROLLERS; i++) begin
                tag_q[i] <= '0;
                val_q[i] <= '0;
            end
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            drop_q <= '0;
            en_q   <= '0;
        end else begin
            if (program_i) begin
                tag_q[0] <= scan_tag_in;
                for (int i = 1; i < NUM_CONTROLLERS; i++) begin
                    tag_q[i] <= tag_q[i-1];
                end
            end
            if (deliver) begin
                for (int i = 0; i < NUM_CONTROLLERS; i++) begin
                    if (match[i]) val_q[i] <= head_data;
                end
            end
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
            en_q   <= en_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {bus.in_tag, bus.in_data};
    end

    always_comb begin
        bus.output_value = '0;
        for (int i = 0; i < NUM_CONTROLLERS; i++) begin
            bus.output_value[i*BITWIDTH +: BITWIDTH] = val_q[i];
        end
    end

    assign bus.unit_enable = en_q;
    assign scan_tag_out    = tag_q[NUM_CONTROLLERS-1];
    assign drop_count      = drop_q;
endmodule
